// File: rtl/accm_seq.sv
// Run sequencer for the 7-bit / 16-bit accumulator: clears it, gates N samples, captures SUM/OVF.
// Optional ABORT input enabled by defining ACCM_SEQ_ABORT_EN.
module accm_seq #(
  parameter int W_X   = 7,
  parameter int W_ACC = 16,
  parameter int W_N   = 10
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ACCM_SEQ_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic             START,
  input  logic [W_N-1:0]   N,
  input  logic [W_X-1:0]   X,
  input  logic             XV,
  output logic             XR,
  output logic [W_X-1:0]   X_ACC,
  output logic             ACC_CE,
  output logic             ACC_CLR,
  input  logic [W_ACC-1:0] ACC,
  input  logic             CO,
  output logic             BUSY,
  output logic             DONE,
  output logic [W_ACC-1:0] SUM,
  output logic             OVF
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [W_N-1:0]   r_cnt;
  logic             r_ovf_int;
  logic             r_ce_d;
  logic [W_ACC-1:0] r_sum;
  logic             r_ovf;
  logic             w_carry;
  logic             w_capture;

  assign XR      = (r_state == S_RUN);
  assign X_ACC   = X;
  assign ACC_CE  = XV & XR;
  assign ACC_CLR = (r_state == S_CLR);
  assign BUSY    = (r_state == S_CLR) |
                   (r_state == S_RUN) |
                   (r_state == S_WAIT);
  assign DONE    = (r_state == S_DONE);
  assign SUM     = r_sum;
  assign OVF     = r_ovf;

  // CO is only meaningful the cycle after an add
  assign w_carry   = r_ce_d & CO;
  assign w_capture = (r_state == S_WAIT) &&
                     (w_nxt == S_DONE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (START) w_nxt = S_CLR;
      S_CLR:  w_nxt = (r_cnt != '0) ? S_RUN : S_WAIT;
      S_RUN: begin
        if (ACC_CE && r_cnt == W_N'(1))
          w_nxt = S_WAIT;
      end
      S_WAIT: w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
`ifdef ACCM_SEQ_ABORT_EN
    if (ABORT && BUSY) w_nxt = S_IDLE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ovf_int <= 1'b0;
      r_ce_d    <= 1'b0;
      r_sum     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ce_d <= ACC_CE;
      if (r_state == S_IDLE && START)
        r_cnt <= N;
      else if (ACC_CE)
        r_cnt <= r_cnt - 1'b1;
      if (r_state == S_CLR)
        r_ovf_int <= 1'b0;
      else
        r_ovf_int <= r_ovf_int | w_carry;
      if (w_capture) begin
        r_sum <= ACC;
        r_ovf <= r_ovf_int | w_carry;
      end
    end
  end

endmodule

// File: tb/tb_accm_seq.sv
// Directed bench for accm_seq with a behavioural accumulator datapath.
module tb_accm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        START;
  logic [9:0]  N;
  logic [6:0]  X;
  logic        XV;
  logic        XR;
  logic [6:0]  X_ACC;
  logic        ACC_CE;
  logic        ACC_CLR;
  logic [15:0] ACC = 16'd0;
  logic        CO  = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic [15:0] SUM;
  logic        OVF;
`ifdef ACCM_SEQ_ABORT_EN
  logic        ABORT = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  accm_seq dut (
    .clk     (clk),
    .rst     (rst),
`ifdef ACCM_SEQ_ABORT_EN
    .ABORT   (ABORT),
`endif
    .START   (START),
    .N       (N),
    .X       (X),
    .XV      (XV),
    .XR      (XR),
    .X_ACC   (X_ACC),
    .ACC_CE  (ACC_CE),
    .ACC_CLR (ACC_CLR),
    .ACC     (ACC),
    .CO      (CO),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .SUM     (SUM),
    .OVF     (OVF)
  );

  // Accumulator datapath: clear has priority, add is zero-extended
  always @(posedge clk) begin
    if (ACC_CLR) begin
      ACC <= 16'd0;
      CO  <= 1'b0;
    end else if (ACC_CE) begin
      {CO, ACC} <= {1'b0, ACC} + {10'd0, X_ACC};
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int x;
    int n;
    int mode;
    int sp1;
    int sp2;
    int e_done;
    int e_sum;
    int e_ovf;
    int e_xr0;
    int e_xr1;
  } vec_t;

  function automatic logic xv_at(input int mode, input int cyc);
    logic [6:0] pat;
    pat = 7'b1011001;
    if (mode == 0) return 1'b1;
    if (cyc >= 2 && cyc <= 8) return pat[cyc-2];
    return 1'b0;
  endfunction

  task automatic do_run(input vec_t v, input int id);
    int cyc, ce, clr, clrc, xr0, xr1, dn, post;
    bit fin;
    string t;
    cyc = 0; ce = 0; clr = 0; clrc = -1;
    xr0 = -1; xr1 = -1; dn = -1; fin = 0; post = 0;
    t = $sformatf("v%0d", id);
    X = v.x[6:0];
    N = v.n[9:0];
    START = 1'b1;
    XV = xv_at(v.mode, 0);
    while (!fin && cyc <= v.n + 20) begin
      @(negedge clk);
      if (ACC_CE) ce++;
      if (ACC_CLR) begin clr++; clrc = cyc; end
      if (XR) begin
        if (xr0 < 0) xr0 = cyc;
        xr1 = cyc;
      end
      if (DONE) begin
        dn = cyc;
        fin = 1;
        chk({t, " sum"}, int'(SUM), v.e_sum);
        chk({t, " ovf"}, int'(OVF), v.e_ovf);
        chk({t, " busy_in_done"}, int'(BUSY), 0);
      end
      @(posedge clk); #1;
      cyc++;
      START = (cyc == v.sp1 || cyc == v.sp2);
      XV = xv_at(v.mode, cyc);
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no DONE within %0d cycles", t, cyc);
    end
    START = 1'b0;
    XV = 1'b0;
    chk({t, " done_cyc"}, dn, v.e_done);
    chk({t, " ce_cnt"}, ce, v.n);
    chk({t, " clr_cnt"}, clr, 1);
    chk({t, " clr_cyc"}, clrc, 1);
    chk({t, " xr_first"}, xr0, v.e_xr0);
    chk({t, " xr_last"}, xr1, v.e_xr1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (BUSY || DONE) post++;
    end
    chk({t, " idle_after"}, post, 0);
    @(posedge clk); #1;
  endtask

  vec_t vt[8];

  initial begin
    int dcnt;
    vt[0] = '{100,    5, 0,  4,  8,    8,   500, 0, 2,    6};
    vt[1] = '{127,  600, 0, -1, -1,  603, 10664, 1, 2,  601};
    vt[2] = '{1,      3, 0, -1, -1,    6,     3, 0, 2,    4};
    vt[3] = '{100,    4, 1, -1, -1,   10,   400, 0, 2,    8};
    vt[4] = '{127, 1023, 0, -1, -1, 1026, 64385, 1, 2, 1024};
    vt[5] = '{55,     0, 0, -1, -1,    3,     0, 0, -1,  -1};
    vt[6] = '{127,  516, 0, -1, -1,  519, 65532, 0, 2,  517};
    vt[7] = '{127,  517, 0, -1, -1,  520,   123, 1, 2,  518};

    rst = 1'b1; START = 1'b0; N = '0; X = '0; XV = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", int'(BUSY), 0);
    chk("rst xr", int'(XR), 0);
    chk("rst done", int'(DONE), 0);
    chk("rst clr", int'(ACC_CLR), 0);
    chk("rst sum", int'(SUM), 0);
    chk("rst ovf", int'(OVF), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_run(vt[i], i);

    // reset in the middle of a run
    X = 7'd100; N = 10'd10; XV = 1'b1; START = 1'b1;
    @(posedge clk); #1; START = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst xr_before", int'(XR), 1);
    @(posedge clk); #1; rst = 1'b0; XV = 1'b0;
    @(negedge clk);
    chk("mid_rst busy", int'(BUSY), 0);
    chk("mid_rst xr", int'(XR), 0);
    chk("mid_rst sum", int'(SUM), 0);
    chk("mid_rst ovf", int'(OVF), 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (DONE) dcnt++;
    end
    chk("mid_rst no_done", dcnt, 0);
    @(posedge clk); #1;
    do_run(vt[0], 8);

`ifdef ACCM_SEQ_ABORT_EN
    X = 7'd100; N = 10'd10; XV = 1'b1; START = 1'b1;
    @(posedge clk); #1; START = 1'b0;
    repeat (4) @(posedge clk);
    #1; ABORT = 1'b1;
    @(negedge clk);
    chk("abort ce_same_cycle", int'(ACC_CE), 1);
    @(posedge clk); #1; ABORT = 1'b0; XV = 1'b0;
    @(negedge clk);
    chk("abort busy", int'(BUSY), 0);
    chk("abort xr", int'(XR), 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (DONE) dcnt++;
    end
    chk("abort no_done", dcnt, 0);
    chk("abort sum_kept", int'(SUM), 500);
    chk("abort ovf_kept", int'(OVF), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accm_seq.md
Name: accm_seq

Overview:
- Sequencer for the 7-bit-input / 16-bit accumulator datapath (ACC[15:0], CO).
- On START it clears the accumulator, then gates exactly N accepted samples into it over a valid/ready stream.
- It captures the final sum and a sticky overflow flag, then pulses DONE.
- Sits between the sample source and the accumulator; owns the accumulator's clear and enable.

Parameters:
W_X, 7, sample width (X, X_ACC)
W_ACC, 16, accumulator width (ACC, SUM)
W_N, 10, sample-count width (N)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
START  in  1  begin a run; sampled only in IDLE
N  in  W_N  number of samples for the run; latched on accepted START
X  in  W_X  sample from source
XV  in  1  sample valid
XR  out  1  sample ready (high only in RUN)
X_ACC  out  W_X  sample to accumulator; equals X combinationally
ACC_CE  out  1  accumulator add enable; equals XV&XR combinationally
ACC_CLR  out  1  accumulator clear
ACC  in  W_ACC  accumulator value from datapath
CO  in  1  carry of most recent datapath addition, registered with ACC
BUSY  out  1  high in CLR, RUN, WAIT
DONE  out  1  one-cycle completion pulse
SUM  out  W_ACC  captured result; held until next capture
OVF  out  1  captured overflow; held until next capture

Behaviour:
- Datapath contract (fixed):
  - On a rising edge, ACC_CLR=1 gives ACC<=0, CO<=0. CLR has priority.
  - Else ACC_CE=1 gives {CO,ACC}<=ACC+X_ACC, with X_ACC zero-extended.
  - Results are visible the following cycle.
- Reset: state=IDLE, CNT=0, ovf_int=0, ce_d=0. SUM=0, OVF=0, DONE=0, BUSY=0, XR=0, ACC_CLR=0.
- Reset mid-run aborts silently: no DONE, SUM/OVF forced to 0.
- States: IDLE, CLR, RUN, WAIT, DONE (registered FSM).
- IDLE: START=1 gives CNT<=N and next=CLR. START is ignored in every other state.
- CLR: ACC_CLR=1 and ovf_int<=0. Next=RUN if CNT!=0, else WAIT.
- RUN:
  - XR=1. Each cycle with XV=1 is an accept: ACC_CE=1 and CNT<=CNT-1.
  - Accept with CNT==1 gives next=WAIT.
  - XV=0 stalls with no add and no timeout.
- ce_d <= ACC_CE every cycle. ovf_int <= ovf_int | (ce_d & CO), so every add's carry is seen.
- WAIT (1 cycle; ACC/CO reflect the last add): SUM<=ACC, OVF<=ovf_int|(ce_d&CO). Next=DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE. A START in this cycle is ignored.
- Latency with XV held high: START at cycle 0 gives DONE at cycle N+3. N=0 gives DONE at cycle 3 with SUM=0, OVF=0.
- Arithmetic: ACC wraps modulo 2^W_ACC. Any carry out in the run sets OVF. SUM is the wrapped value.
- Maximum N = 2^W_N-1. No saturation.

Optional Feature:
- Macro: ACCM_SEQ_ABORT_EN.
- When defined:
  - Adds input ABORT (1 bit).
  - ABORT=1 in CLR/RUN/WAIT gives next=IDLE. XR drops next cycle, there is no DONE, and SUM/OVF keep their previous values.
  - ABORT in IDLE/DONE has no effect.
  - ABORT beats an accept in the same cycle: ACC_CE is still driven that cycle, but the result is discarded.
- When undefined: no ABORT port and no abort logic.

Test Plan:
- Bench provides a behavioural accumulator model per the datapath contract.
- X=100, XV=1 constant, START with N=5 at cycle 0 -> ACC_CLR high cycle 1, XR high cycles 2..6, DONE at cycle 8, SUM=500, OVF=0.
- X=127, N=600, XV=1 -> SUM=10664 (76200 mod 65536), OVF=1. Second run X=1, N=3 -> SUM=3, OVF=0 (sticky flag cleared by CLR).
- X=100, N=4, XV toggling 1,0,0,1,1,0,1 -> exactly 4 ACC_CE pulses, SUM=400. DONE two cycles after the 4th accept.
- START with N=0 -> ACC_CLR one cycle, no XR, DONE at cycle 3, SUM=0, OVF=0. START pulsed during RUN/DONE -> ignored, no extra run.
- rst=1 in RUN after 3 of N=10 samples -> next cycle IDLE, BUSY=0, XR=0, SUM=0, OVF=0, no DONE. A new START runs correctly from a cleared ACC.
- (ACCM_SEQ_ABORT_EN) N=10, X=100, ABORT at 4th accept -> IDLE, no DONE, SUM keeps the prior run's 500.
